// File: rtl/prio_k_sequencer_pkg.sv
// Shared definitions for the top-K priority sequencer: FSM state encoding,
// default sizing constants and the index-width helper.
package prio_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EMIT = 1'b1
   } state_t;

   localparam int DEF_WIDTH   = 12;
   localparam int DEF_MAX_OUT = 2;

   // Number of bits needed to index n items, never less than one bit.
   function automatic int idx_width(input int n);
      int w;
      w = $clog2(n);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/prio_k_sequencer_if.sv
// Request/beat bus of the top-K priority sequencer.
// Handshake: a request is accepted on a rising clock edge where i_start=1 and
// o_ready=1. A beat transfers on a rising edge where o_valid=1 and i_ready=1;
// while o_valid=1 and i_ready=0 the beat payload (o_index/o_none/o_last)
// holds stable, and o_valid only drops after a transfer, a flush or reset.
interface prio_k_sequencer_if #(
   parameter int WIDTH = 12,
   parameter int IDX_W = 4
);
   logic             i_start;
   logic [WIDTH-1:0] i_value;
   logic             i_flush;
   logic             o_ready;
   logic             o_valid;
   logic             i_ready;
   logic [IDX_W-1:0] o_index;
   logic             o_none;
   logic             o_last;

   // Request source / beat sink side.
   modport master (
      output i_start, i_value, i_flush, i_ready,
      input  o_ready, o_valid, o_index, o_none, o_last
   );

   // Sequencer side.
   modport slave (
      input  i_start, i_value, i_flush, i_ready,
      output o_ready, o_valid, o_index, o_none, o_last
   );
endinterface

// File: rtl/prio_k_sequencer_find.sv
// Combinational priority finder: index of the highest set bit (lowest set
// bit when PRIO_LSB_FIRST_EN is defined) plus an any-set flag.
// Returns index 0 when no bit is set.
module prio_find #(
   parameter int WIDTH = 12,
   parameter int IDX_W = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Scan so that the winning bit is the last one to overwrite idx.
   always_comb begin
      idx = '0;
      any = 1'b0;
`ifdef PRIO_LSB_FIRST_EN
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
`else
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) begin
            idx = IDX_W'(i);
            any = 1'b1;
         end
      end
`endif
   end

endmodule

// File: rtl/prio_k_sequencer.sv
// Top-K priority sequencer: latches a request vector and emits the indices of
// its set bits one beat at a time, highest priority first, at most MAX_OUT
// beats per request. An all-zero request yields a single o_none beat.
// Optional build macro PRIO_LSB_FIRST_EN makes bit 0 the highest priority.
module prio_k_sequencer
   import prio_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int IDX_W   = idx_width(DEF_WIDTH),
   parameter int MAX_OUT = DEF_MAX_OUT
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   prio_k_sequencer_if.slave     bus,
   output state_t                dbg_state
);

   localparam int CNT_W = idx_width(MAX_OUT);

   state_t           state;
   logic [WIDTH-1:0] work;
   logic [CNT_W-1:0] cnt;
   logic             ready_q;
   logic             valid_q;

   logic [IDX_W-1:0] find_idx;
   logic             find_any;
   logic [WIDTH-1:0] clr_mask;
   logic             one_hot;
   logic             beat_last;

   prio_find #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_find (
      .vec (work),
      .idx (find_idx),
      .any (find_any)
   );

   // Beat attributes, derived only from registered state.
   always_comb begin
      clr_mask  = WIDTH'(1) << find_idx;
      one_hot   = find_any && ((work & (work - WIDTH'(1))) == '0);
      beat_last = !find_any || one_hot || (cnt == CNT_W'(MAX_OUT - 1));
   end

   // FSM, working vector and beat counter; ready/valid are registered here.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= ST_IDLE;
         work    <= '0;
         cnt     <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               // A flush in IDLE also masks a simultaneous start.
               if (bus.i_start && !bus.i_flush) begin
                  work    <= bus.i_value;
                  cnt     <= '0;
                  state   <= ST_EMIT;
                  ready_q <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            ST_EMIT: begin
               if (bus.i_flush) begin
                  // Flush wins over a same-cycle transfer.
                  work    <= '0;
                  cnt     <= '0;
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
                  valid_q <= 1'b0;
               end else if (bus.i_ready) begin
                  if (beat_last) begin
                     work    <= '0;
                     cnt     <= '0;
                     state   <= ST_IDLE;
                     ready_q <= 1'b1;
                     valid_q <= 1'b0;
                  end else begin
                     work <= work & ~clr_mask;
                     cnt  <= cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               work    <= '0;
               cnt     <= '0;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Payload is forced to zero whenever no beat is offered.
   assign bus.o_ready = ready_q;
   assign bus.o_valid = valid_q;
   assign bus.o_index = valid_q ? find_idx : '0;
   assign bus.o_none  = valid_q && !find_any;
   assign bus.o_last  = valid_q && beat_last;
   assign dbg_state   = state;

endmodule

// File: tb/tb_prio_k_sequencer.sv
// Bench for prio_k_sequencer: a default instance (MAX_OUT=2) and a MAX_OUT=4
// instance share stimulus; sel picks which one is driven and observed.
// Expected beats come from an independent model pushed into exp_q.
module tb_prio_k_sequencer;
   import prio_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_r = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   prio_k_sequencer_if #(.WIDTH(12), .IDX_W(4)) bus0 ();
   prio_k_sequencer_if #(.WIDTH(12), .IDX_W(4)) bus1 ();
   state_t dbg0, dbg1;

   prio_k_sequencer #(.WIDTH(12), .IDX_W(4), .MAX_OUT(2)) dut0 (
      .i_clk (clk), .i_reset (reset_r), .bus (bus0), .dbg_state (dbg0)
   );
   prio_k_sequencer #(.WIDTH(12), .IDX_W(4), .MAX_OUT(4)) dut1 (
      .i_clk (clk), .i_reset (reset_r), .bus (bus1), .dbg_state (dbg1)
   );

   int          sel = 0;
   logic        start_r = 1'b0;
   logic [11:0] value_r = '0;
   logic        flush_r = 1'b0;
   logic        ready_r = 1'b0;

   assign bus0.i_start = start_r && (sel == 0);
   assign bus1.i_start = start_r && (sel == 1);
   assign bus0.i_value = value_r;
   assign bus1.i_value = value_r;
   assign bus0.i_flush = flush_r;
   assign bus1.i_flush = flush_r;
   assign bus0.i_ready = ready_r;
   assign bus1.i_ready = ready_r;

   logic       obs_valid, obs_ready;
   logic [5:0] obs_beat; // {none, last, index}
   assign obs_valid = (sel == 1) ? bus1.o_valid : bus0.o_valid;
   assign obs_ready = (sel == 1) ? bus1.o_ready : bus0.o_ready;
   assign obs_beat  = (sel == 1) ? {bus1.o_none, bus1.o_last, bus1.o_index}
                                 : {bus0.o_none, bus0.o_last, bus0.o_index};

   // ---------------- scoreboard ----------------
   logic [5:0] exp_q[$];
   int checks = 0;
   int failures = 0;

   // Expected beat list for a request vector v under a beat limit max_out.
   function automatic void model_push(input logic [11:0] v, input int max_out);
      int n;
      int total;
      int b;
      n = 0;
      total = $countones(v);
      if (v == 12'h000) begin
         exp_q.push_back({1'b1, 1'b1, 4'd0});
         return;
      end
      for (int k = 0; k < 12; k++) begin
`ifdef PRIO_LSB_FIRST_EN
         b = k;
`else
         b = 11 - k;
`endif
         if (v[b] && n < max_out) begin
            n++;
            exp_q.push_back({1'b0, (n == max_out) || (n == total), 4'(b)});
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic start_req(input logic [11:0] v, input bit do_push);
      @(negedge clk);
      checks++;
      if (obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL start_ready: o_ready=%b expected 1", obs_ready);
      end
      start_r = 1'b1;
      value_r = v;
      if (do_push) model_push(v, (sel == 1) ? 4 : 2);
   endtask

   // Consume beats with i_ready following pat, checking order and stall hold.
   task automatic drain(input logic [15:0] pat);
      logic       stalled;
      logic [5:0] held;
      logic [5:0] exp;
      bit         done;
      stalled = 1'b0;
      held = '0;
      done = 1'b0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         start_r = 1'b0;
         ready_r = pat[c % 16];
         if (obs_valid) begin
            if (stalled) begin
               checks++;
               if (obs_beat !== held) begin
                  failures++;
                  $display("FAIL stall_hold: beat=%h expected %h", obs_beat, held);
               end
            end
            if (ready_r) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL extra_beat: beat=%h expected none", obs_beat);
                  done = 1'b1;
               end else begin
                  exp = exp_q.pop_front();
                  checks++;
                  if (obs_beat !== exp) begin
                     failures++;
                     $display("FAIL beat: {none,last,idx}=%h expected %h", obs_beat, exp);
                  end
                  if (exp_q.size() == 0) done = 1'b1;
               end
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held = obs_beat;
            end
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL drain_timeout: %0d beats outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      ready_r = 1'b0;
      checks++;
      if (obs_ready !== 1'b1 || obs_valid !== 1'b0) begin
         failures++;
         $display("FAIL return_idle: ready=%b valid=%b expected 1 0", obs_ready, obs_valid);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      sel = 0;
      repeat (2) @(negedge clk);
      reset_r = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus0.o_ready, bus0.o_valid, bus0.o_index, bus0.o_none, bus0.o_last} !== 8'b1000_0000) begin
         failures++;
         $display("FAIL reset_outputs: rdy=%b vld=%b idx=%0d none=%b last=%b expected 1 0 0 0 0",
                  bus0.o_ready, bus0.o_valid, bus0.o_index, bus0.o_none, bus0.o_last);
      end
      checks++;
      if (dbg0 !== ST_IDLE || dbg1 !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state: %0d %0d expected IDLE", dbg0, dbg1);
      end
   endtask

   task automatic test_basic();
      sel = 0;
      start_req(12'hA04, 1'b1);
      drain(16'hFFFF);
      start_req(12'h000, 1'b1);
      drain(16'hFFFF);
   endtask

   task automatic test_max_out();
      sel = 1;
      start_req(12'h801, 1'b1);
      drain(16'hFFF9); // i_ready 1,0,0,1,...
      start_req(12'hFFF, 1'b1);
      drain(16'hFFFF);
      sel = 0;
   endtask

   task automatic test_flush();
      logic [5:0] exp;
      sel = 0;
      start_req(12'hFFF, 1'b1);
      exp = exp_q.pop_front();
      exp_q.delete();
      @(negedge clk);
      start_r = 1'b0;
      ready_r = 1'b1;
      flush_r = 1'b1;
      checks++;
      if (obs_valid !== 1'b1 || obs_beat !== exp) begin
         failures++;
         $display("FAIL flush_first_beat: valid=%b beat=%h expected 1 %h", obs_valid, obs_beat, exp);
      end
      @(negedge clk);
      flush_r = 1'b0;
      ready_r = 1'b0;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_idle: valid=%b ready=%b expected 0 1", obs_valid, obs_ready);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (obs_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_beat: valid=%b expected 0", obs_valid);
      end
      // Flush in IDLE masks a same-cycle start.
      start_r = 1'b1;
      value_r = 12'hFFF;
      flush_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      flush_r = 1'b0;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1) begin
         failures++;
         $display("FAIL idle_flush_start: valid=%b ready=%b expected 0 1", obs_valid, obs_ready);
      end
      start_req(12'h010, 1'b1);
      drain(16'hFFFF);
   endtask

   task automatic test_async_reset();
      sel = 0;
      start_req(12'hFFF, 1'b0);
      @(negedge clk);
      start_r = 1'b0;
      ready_r = 1'b0;
      checks++;
      if (obs_valid !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_valid: valid=%b expected 1", obs_valid);
      end
      #2 reset_r = 1'b1;
      #1;
      checks++;
      if (obs_valid !== 1'b0 || obs_ready !== 1'b1 || obs_beat !== 6'd0) begin
         failures++;
         $display("FAIL async_reset: valid=%b ready=%b beat=%h expected 0 1 00",
                  obs_valid, obs_ready, obs_beat);
      end
      @(negedge clk);
      reset_r = 1'b0;
      // A start during EMIT must not disturb the running request.
      start_req(12'hA04, 1'b1);
      @(negedge clk);
      start_r = 1'b1;
      value_r = 12'h00F;
      ready_r = 1'b0;
      drain(16'hFFFF);
   endtask

   task automatic test_back_to_back();
      logic [11:0] v;
      logic [15:0] pat;
      for (int n = 0; n < 6; n++) begin
         sel = n % 2;
         v = 12'($urandom_range(0, 4095));
         pat = 16'($urandom_range(0, 65535)) | 16'h0001;
         start_req(v, 1'b1);
         drain(pat);
      end
      sel = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_max_out();
      test_flush();
      test_async_reset();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prio_k_sequencer.md
Name: prio_k_sequencer

Overview:
Parametrised successor of the dual priority encoder. It latches a request vector and emits the indices of its set bits one per beat, highest-priority first. At most MAX_OUT indices are emitted per request. Output uses a valid/ready handshake, so downstream arbiters and schedulers can consume the top-K requesters sequentially instead of through fixed first/second outputs.

Parameters:
WIDTH, 12, request vector width (>=2)
IDX_W, $clog2(WIDTH) (4 at default), index output width
MAX_OUT, 2, maximum indices emitted per request (1..WIDTH)

Ports:
i_clk  input  1  clock, rising edge
i_reset  input  1  asynchronous, active-high reset
i_start  input  1  request strobe; accepted only when o_ready=1
i_value  input  WIDTH  request vector, sampled on accepted i_start
i_flush  input  1  synchronous abort of current request
o_ready  output  1  sequencer idle, can accept i_start
o_valid  output  1  o_index/o_none/o_last valid this cycle
i_ready  input  1  downstream accepts current beat
o_index  output  IDX_W  bit index of current highest remaining set bit
o_none  output  1  current beat reports an all-zero request
o_last  output  1  current beat is the final beat of this request

Behaviour:
- Reset (async assert, sync release): state=IDLE, working vector=0, beat count=0. Outputs: o_ready=1, o_valid=0, o_index=0, o_none=0, o_last=0.
- States: IDLE, EMIT.
- IDLE: o_ready=1, o_valid=0. On i_start, latch i_value into the working vector, clear the beat count, go to EMIT next cycle. First beat appears 1 cycle after i_start.
- EMIT: o_ready=0, o_valid=1.
  - o_index = highest set bit of the working vector. Priority is fixed: bit WIDTH-1 highest.
  - o_index is derived only from registered state; there is no combinational path from i_value.
- Zero request: if the latched vector is 0, emit exactly one beat with o_none=1, o_last=1, o_index=0.
- Beat transfer occurs when o_valid && i_ready. On transfer:
  - clear the o_index bit in the working vector;
  - increment the beat count;
  - if o_last=1, return to IDLE (o_ready=1 the next cycle).
- o_last=1 when the beat count = MAX_OUT-1, or the working vector has exactly one set bit, or o_none=1.
- Back-pressure: with o_valid=1 and i_ready=0, o_index/o_none/o_last hold stable. o_valid never drops without a transfer, except on i_flush or reset.
- i_flush is sampled every cycle and has priority over a transfer in the same cycle. It forces IDLE next cycle and clears the working vector and count. No beat is counted as transferred in the flush cycle. i_flush in IDLE has no effect, and i_start is ignored in that cycle.
- i_start while o_ready=0 is ignored; there is no queueing.
- Back-to-back: a return to IDLE and a new i_start give minimum 2 cycles between the last beat of one request and the first beat of the next.
- Reset asserted mid-EMIT: immediate return to reset values; the partial sequence is discarded.
- MAX_OUT >= popcount(i_value): all set bits are emitted and the sequence ends early on the last one.

Optional Feature:
Macro PRIO_LSB_FIRST_EN.
- Defined: priority is inverted. Bit 0 is highest and o_index reports the lowest remaining set bit. All other behaviour is unchanged.
- Undefined: MSB-first as above.

Decomposition:
- Package prio_pkg holds:
  - state encoding (ST_IDLE, ST_EMIT);
  - index-width helper function (clog2 with minimum 1);
  - default WIDTH/MAX_OUT constants.
- One sub-module, prio_find: combinational, parametrised WIDTH/IDX_W. It returns the highest (or lowest under PRIO_LSB_FIRST_EN) set-bit index plus an any-set flag.
- The sequencer instantiates one prio_find on the working vector. It owns the FSM, the beat counter and the clear mask.

Test Plan:
- Defaults, i_value=12'hA04, i_ready=1: beats o_index=11, then 9 (o_last=1). Bit 2 is never emitted; o_ready=1 the next cycle.
- i_value=12'h000: one beat with o_none=1, o_last=1, o_index=0, then IDLE.
- MAX_OUT=4, i_value=12'h801, i_ready toggling 1,0,0,1: beats 11, 0 (o_last=1 on 0, popcount 2). o_index holds 0 across the two stall cycles.
- Defaults, i_value=12'hFFF, i_flush asserted together with i_ready on the first beat (o_index=11): IDLE next cycle, no second beat. A new i_start with 12'h010 yields o_index=4, o_last=1.
- i_reset asserted asynchronously mid-EMIT, between clock edges: o_valid drops immediately, o_ready=1, o_index=0. i_start during EMIT is ignored (next beats unchanged).
- PRIO_LSB_FIRST_EN defined, i_value=12'hA04: beats 2, then 9 (o_last=1).
